car_cmd_uart_rx: RTL and testbench
==================================

Name: car_cmd_uart_rx

Overview:
UART receiver and decoder for the car command byte that the FPGA command transmitter emits (8N1, LSB first, payload {speed_level[3:0], move_cmd[3:0]}).
Sits at the motor-controller end of the link, or in an FPGA loopback bench. It recovers move_cmd and speed_level and presents them on a valid/ready handshake.
It flags framing, decode and overrun errors. A link watchdog injects a stop command when no valid frame arrives in time.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50_000_000/115_200).
WATCHDOG_CLKS, 25_000_000, cycles without a good frame before a forced stop (0.5 s at 50 MHz); must be > 10*CLKS_PER_BIT.

Ports:
clk  input  1  system clock (CLOCK_50)
rst_n  input  1  asynchronous active-low reset
uart_in  input  1  serial line, idle high, asynchronous to clk
move_cmd  output  4  decoded movement code (0000 fwd … 0111 rev-right, 1000 stop)
speed_level  output  4  decoded speed level
valid  output  1  move_cmd/speed_level hold an unconsumed command
ready  input  1  consumer accepts the command when valid&&ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
cmd_err  output  1  one-cycle pulse: byte framed correctly but move_cmd code > 4'b1000
overrun  output  1  one-cycle pulse: unconsumed command overwritten
timeout  output  1  level: watchdog expired, cleared by next good frame

Behaviour:
- Reset (async, rst_n low): move_cmd=4'b1000, speed_level=0, valid=0, frame_err=cmd_err=overrun=0, timeout=0. Synchroniser flops preset to 1. FSM goes to IDLE. Bit and baud counters go to 0. Watchdog counter goes to 0.
- uart_in passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- FSM:
  - IDLE: synced line low -> START, baud counter=0.
  - START: at count CLKS_PER_BIT/2-1, resample the line. If low -> DATA and counter=0. If high (glitch) -> IDLE, no flag.
  - DATA: sample every CLKS_PER_BIT cycles, i.e. at bit centre. Shift LSB first. After the 8th sample -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - High: the frame is good; go to IDLE.
    - Low: pulse frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synced line is high, then go to IDLE. This covers break conditions and prevents spurious start detection.
- Decode on a good frame:
  - byte[3:0] > 4'b1000: pulse cmd_err and drop the byte. Outputs are unchanged and the watchdog is not reset.
  - Otherwise, on the edge after the stop-bit sample cycle: move_cmd<=byte[3:0], speed_level<=byte[7:4], valid<=1, watchdog<=0, timeout<=0.
- Handshake:
  - valid stays high, with stable payload, until a cycle with valid&&ready. valid falls on the following edge.
  - A new good frame while valid=1 and ready=0: the newest frame wins. Overwrite the payload and pulse overrun.
  - A new load in the same cycle as valid&&ready: the load wins, valid stays 1, and no overrun is raised.
- Watchdog:
  - Increments every cycle when timeout=0. Held at 0 while timeout=1.
  - On reaching WATCHDOG_CLKS-1: timeout<=1, move_cmd<=4'b1000, speed_level<=0, valid<=1. This injects a synthetic stop under the same handshake and overrun rules.
  - One injection per expiry.
  - A good frame in the same cycle as expiry: the frame wins, and timeout stays 0.
- Latency: valid is asserted exactly 1 clk after the stop-bit sample cycle. Nominally about 9.5*CLKS_PER_BIT+3 cycles after the start-bit falling edge at the pin.
- Back-to-back frames, with the stop bit immediately followed by the next start bit, must be received without loss.
- Error pulses last exactly one cycle and are mutually exclusive per frame.

Test Plan:
(Bench uses CLKS_PER_BIT=16, WATCHDOG_CLKS=4000.)
1. Send 0x12 -> move_cmd=4'b0010, speed_level=4'b0001, valid=1 at 1 clk after the stop sample. Hold ready=0 for 50 cycles -> payload stable. Pulse ready -> valid=0 next edge.
2. Send 0x30, 0x21, 0x18 back-to-back with ready=1 -> three handshakes in order with payloads (0,3), (1,2), (8,1). No error pulses.
3. Send 0x05 with ready=0, then 0x17 -> overrun pulses once. Payload becomes move_cmd=0111, speed=0001, and valid stays 1.
4. Send 0x45 with the stop bit driven low, then hold the line low for 40 bit times -> single frame_err pulse, no valid, no new start until the line returns high. A following 0x00 decodes correctly.
5. Send 0x09 -> single cmd_err pulse, valid stays 0, prior payload unchanged.
6. Idle for 4000 cycles after a good frame -> timeout=1, move_cmd=1000, speed=0, valid=1. Send 0x23 -> timeout=0 and the payload updates. Assert rst_n=0 mid-frame -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/car_cmd_uart_rx_if.sv
// Command-side bundle of the car command UART receiver.
// The receiver drives the payload, status and handshake; the consumer answers with ready.
interface car_cmd_uart_rx_if;
    logic [3:0] move_cmd;
    logic [3:0] speed_level;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       cmd_err;
    logic       overrun;
    logic       timeout;

    modport master (
        output move_cmd, speed_level, valid, frame_err, cmd_err, overrun, timeout,
        input  ready
    );

    modport slave (
        input  move_cmd, speed_level, valid, frame_err, cmd_err, overrun, timeout,
        output ready
    );
endinterface

// File: rtl/car_cmd_uart_rx.sv
// 8N1 receiver for the car command byte {speed_level, move_cmd}, with a valid/ready
// output, framing/decode/overrun flags and a link watchdog that injects a stop command.
module car_cmd_uart_rx #(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned WATCHDOG_CLKS = 25_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                uart_in,
    car_cmd_uart_rx_if.master   cmd
);
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned WW   = $clog2(WATCHDOG_CLKS);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam logic [3:0]  STOP_CMD = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    logic          sync1_q, sync2_q;
    logic          rx;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;

    logic [3:0]    move_q, move_d;
    logic [3:0]    speed_q, speed_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          cmd_err_q, cmd_err_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic [WW-1:0] wd_q, wd_d;

    logic baud_done, stop_smp, frame_load, cmd_bad, frm_bad, wd_expire, inject, any_load;

    // Two-flop synchroniser, preset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_in;
            sync2_q <= sync1_q;
        end
    end

    assign rx        = sync2_q;
    assign baud_done = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (!rx) state_q <= S_START;
                end
                S_START: begin
                    if (cnt_q == CW'(HALF - 1)) begin
                        cnt_q   <= '0;
                        // A line that is high again at mid start bit was a glitch.
                        state_q <= rx ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        cnt_q   <= '0;
                        shift_q <= {rx, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        cnt_q   <= '0;
                        state_q <= rx ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    cnt_q <= '0;
                    if (rx) state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    bit_q   <= '0;
                end
            endcase
        end
    end

    // Frame outcome is decided in the stop-bit sample cycle and lands on the next edge.
    assign stop_smp   = (state_q == S_STOP) && baud_done;
    assign frame_load = stop_smp && rx && (shift_q[3:0] <= STOP_CMD);
    assign cmd_bad    = stop_smp && rx && (shift_q[3:0] > STOP_CMD);
    assign frm_bad    = stop_smp && !rx;
    assign wd_expire  = !timeout_q && (wd_q == WW'(WATCHDOG_CLKS - 1));
    assign inject     = wd_expire && !frame_load;
    assign any_load   = frame_load || inject;

    always_comb begin
        move_d      = move_q;
        speed_d     = speed_q;
        valid_d     = valid_q;
        timeout_d   = timeout_q;
        wd_d        = wd_q;
        frame_err_d = frm_bad;
        cmd_err_d   = cmd_bad;
        // A load coinciding with a handshake is not an overwrite of unseen data.
        overrun_d   = any_load && valid_q && !cmd.ready;

        if (frame_load) begin
            move_d    = shift_q[3:0];
            speed_d   = shift_q[7:4];
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            wd_d      = '0;
        end else if (inject) begin
            move_d    = STOP_CMD;
            speed_d   = '0;
            valid_d   = 1'b1;
            timeout_d = 1'b1;
            wd_d      = '0;
        end else begin
            if (valid_q && cmd.ready) valid_d = 1'b0;
            if (!timeout_q) wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_q      <= STOP_CMD;
            speed_q     <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            wd_q        <= '0;
        end else begin
            move_q      <= move_d;
            speed_q     <= speed_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            cmd_err_q   <= cmd_err_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            wd_q        <= wd_d;
        end
    end

    assign cmd.move_cmd    = move_q;
    assign cmd.speed_level = speed_q;
    assign cmd.valid       = valid_q;
    assign cmd.frame_err   = frame_err_q;
    assign cmd.cmd_err     = cmd_err_q;
    assign cmd.overrun     = overrun_q;
    assign cmd.timeout     = timeout_q;

endmodule

// File: tb/tb_car_cmd_uart_rx.sv
// Scoreboard bench for car_cmd_uart_rx: stimulus pushes expected {speed,move} bytes,
// a negedge monitor pops them on every valid&&ready and tallies the error pulses.
module tb_car_cmd_uart_rx;
    localparam int CPB = 16;
    localparam int WD  = 4000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_in = 1'b1;

    car_cmd_uart_rx_if bus ();

    car_cmd_uart_rx #(.CLKS_PER_BIT(CPB), .WATCHDOG_CLKS(WD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart_in (uart_in),
        .cmd     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0, ce_cnt = 0, ov_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stopb);
        uart_in = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (CPB) tick();
        end
        uart_in = stopb;
        repeat (CPB) tick();
    endtask

    task automatic pulse_ready();
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
    endtask

    // Monitor: every accepted command must match the oldest expectation.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.frame_err) fe_cnt++;
                if (bus.cmd_err)   ce_cnt++;
                if (bus.overrun)   ov_cnt++;
                if (bus.valid && bus.ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmd: got move=%0d speed=%0d, expected none",
                                 bus.move_cmd, bus.speed_level);
                    end else begin
                        e = exp_q.pop_front();
                        check("hs_move", bus.move_cmd, e[3:0]);
                        check("hs_speed", bus.speed_level, e[7:4]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL global_timeout: got no finish, expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int lat;
        bit stable;
        bus.ready = 1'b0;
        repeat (3) tick();
        check("rst_move", bus.move_cmd, 8);
        check("rst_speed", bus.speed_level, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_timeout", bus.timeout, 0);
        check("rst_flags", {bus.frame_err, bus.cmd_err, bus.overrun}, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // 1: single frame, latency, hold, handshake
        exp_q.push_back(8'h12);
        lat = -1;
        fork
            send(8'h12, 1'b1);
            begin
                for (int n = 1; n <= 400; n++) begin
                    tick();
                    if (bus.valid) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        check("t1_latency", lat, 155);
        check("t1_move", bus.move_cmd, 2);
        check("t1_speed", bus.speed_level, 1);
        stable = 1'b1;
        repeat (50) begin
            tick();
            if (!(bus.valid && bus.move_cmd == 4'd2 && bus.speed_level == 4'd1)) stable = 1'b0;
        end
        check("t1_stable", stable, 1);
        pulse_ready();
        check("t1_valid_drop", bus.valid, 0);

        // 2: back-to-back frames with ready held high
        bus.ready = 1'b1;
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h18);
        send(8'h30, 1'b1);
        send(8'h21, 1'b1);
        send(8'h18, 1'b1);
        repeat (20) tick();
        bus.ready = 1'b0;
        check("t2_drained", exp_q.size(), 0);
        check("t2_frame_err", fe_cnt, 0);
        check("t2_cmd_err", ce_cnt, 0);
        check("t2_overrun", ov_cnt, 0);

        // 3: overwrite of an unconsumed command
        exp_q.push_back(8'h17);
        send(8'h05, 1'b1);
        send(8'h17, 1'b1);
        repeat (5) tick();
        check("t3_overrun", ov_cnt, 1);
        check("t3_valid", bus.valid, 1);
        check("t3_move", bus.move_cmd, 7);
        check("t3_speed", bus.speed_level, 1);
        pulse_ready();
        check("t3_drained", exp_q.size(), 0);

        // 4: bad stop bit followed by a long break, then a clean frame
        send(8'h45, 1'b0);
        repeat (40 * CPB) tick();
        check("t4_frame_err", fe_cnt, 1);
        check("t4_no_valid", bus.valid, 0);
        uart_in = 1'b1;
        repeat (32) tick();
        exp_q.push_back(8'h00);
        send(8'h00, 1'b1);
        repeat (5) tick();
        check("t4_valid", bus.valid, 1);
        check("t4_move", bus.move_cmd, 0);
        pulse_ready();

        // 5: illegal move code
        send(8'h09, 1'b1);
        repeat (5) tick();
        check("t5_cmd_err", ce_cnt, 1);
        check("t5_valid", bus.valid, 0);
        check("t5_move", bus.move_cmd, 0);
        check("t5_speed", bus.speed_level, 0);

        // 6: watchdog injection, recovery, then reset mid-frame
        exp_q.push_back(8'h08);
        for (int n = 0; n < 5000 && !bus.timeout; n++) tick();
        check("t6_timeout", bus.timeout, 1);
        check("t6_move", bus.move_cmd, 8);
        check("t6_speed", bus.speed_level, 0);
        check("t6_valid", bus.valid, 1);
        pulse_ready();
        check("t6_overrun", ov_cnt, 1);
        send(8'h23, 1'b1);
        repeat (3) tick();
        check("t6_timeout_clr", bus.timeout, 0);
        check("t6_valid2", bus.valid, 1);
        check("t6_move2", bus.move_cmd, 3);
        check("t6_speed2", bus.speed_level, 2);
        fork
            send(8'h55, 1'b1);
            begin
                repeat (60) tick();
                rst_n = 1'b0;
                #1;
                check("t6_rst_move", bus.move_cmd, 8);
                check("t6_rst_speed", bus.speed_level, 0);
                check("t6_rst_valid", bus.valid, 0);
                check("t6_rst_timeout", bus.timeout, 0);
            end
        join
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("t6_post_valid", bus.valid, 0);
        check("t6_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
